// File: rtl/ps_responder.sv
// ps_responder: far end of the psen/psincdec/psdone phase-shift handshake.
// Rev 1.0 -- fixed-latency responder with a clamped signed phase offset.
`default_nettype none

module ps_responder #(
  parameter int LATENCY = 12,
  parameter int PS_MAX  = 255,
  parameter int PS_MIN  = -255,
  parameter int PW      = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 psen,
  input  logic                 psincdec,
  input  logic                 ready,
  input  logic                 err_clr,
  output logic                 psdone,
  output logic signed [PW-1:0] phase,
  output logic                 busy,
  output logic                 at_limit,
  output logic                 req_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0]           C_LOAD = 8'(LATENCY - 2);
  localparam logic signed [PW-1:0] C_MAX  = PW'(PS_MAX);
  localparam logic signed [PW-1:0] C_MIN  = PW'(PS_MIN);
  localparam logic signed [PW-1:0] C_ONE  = PW'(1);

  logic [1:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 dir_q, dir_d;
  logic signed [PW-1:0] phase_q, phase_d;
  logic                 lim_q, lim_d;
  logic                 err_q, err_d;
  logic                 req_bad;

  // Any request outside an enabled IDLE cycle is dropped and flagged.
  assign req_bad = psen & ((state_q != S_IDLE) | ~ready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    lim_d   = lim_q;
    case (state_q)
      S_IDLE: begin
        if (psen && ready) begin
          dir_d   = psincdec;
          cnt_d   = C_LOAD;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
          // Phase lands on the edge into DONE so it is valid alongside psdone.
          if (dir_q) begin
            if (phase_q < C_MAX) begin
              phase_d = phase_q + C_ONE;
              lim_d   = 1'b0;
            end else begin
              lim_d   = 1'b1;
            end
          end else begin
            if (phase_q > C_MIN) begin
              phase_d = phase_q - C_ONE;
              lim_d   = 1'b0;
            end else begin
              lim_d   = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (req_bad)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      dir_q   <= 1'b0;
      phase_q <= '0;
      lim_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      lim_q   <= lim_d;
      err_q   <= err_d;
    end
  end

  assign psdone   = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign phase    = phase_q;
  assign at_limit = lim_q;
  assign req_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps_responder.sv
// Scoreboard bench for ps_responder: driver pushes expected completions, monitor pops on psdone.
`default_nettype none

module tb_ps_responder;

  localparam int L    = 12;
  localparam int PMAX = 255;
  localparam int PMIN = -255;
  localparam int PW   = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 psen, psincdec, ready, err_clr;
  logic                 psdone, busy, at_limit, req_err;
  logic signed [PW-1:0] phase;

  ps_responder #(.LATENCY(L), .PS_MAX(PMAX), .PS_MIN(PMIN), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .psen(psen), .psincdec(psincdec), .ready(ready),
    .err_clr(err_clr), .psdone(psdone), .phase(phase), .busy(busy),
    .at_limit(at_limit), .req_err(req_err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { int t; int ph; bit lim; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int m_phase  = 0;
  bit m_err    = 0;
  int next_ok  = 0;
  int acc_n    = 0;
  bit acc_valid = 0;
  bit mon_en   = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_cnt);
  endtask

  // Monitor: psdone timing/phase/limit against the queue, busy against the accept window.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].t < edge_cnt) begin
        e = sb.pop_front();
        chk("psdone_due", edge_cnt, e.t);
      end
      if (psdone) begin
        if (sb.size() == 0) chk("psdone_unexpected", psdone, 0);
        else begin
          e = sb.pop_front();
          chk("psdone_time", edge_cnt, e.t);
          chk("phase_at_done", phase, e.ph);
          chk("at_limit", at_limit, e.lim);
        end
      end
      chk("busy", busy, (acc_valid && edge_cnt >= acc_n && edge_cnt <= acc_n + L - 1) ? 1 : 0);
    end
  end

  // One clock of stimulus with the reference model updated from the behavioural rules.
  task automatic step(input bit en, input bit dir, input bit rdy, input bit clr);
    int n;
    bit bad, lim;
    psen = en; psincdec = dir; ready = rdy; err_clr = clr;
    n = edge_cnt + 1;
    bad = 0;
    if (en) begin
      if (rdy && n >= next_ok) begin
        lim = 0;
        if (dir) begin
          if (m_phase < PMAX) m_phase++; else lim = 1;
        end else begin
          if (m_phase > PMIN) m_phase--; else lim = 1;
        end
        sb.push_back('{n + L - 1, m_phase, lim});
        acc_n = n; acc_valid = 1; next_ok = n + L + 1;
      end else bad = 1;
    end
    if (bad) m_err = 1;
    else if (clr) m_err = 0;
    @(posedge clk);
    @(negedge clk);
    psen = 0; err_clr = 0;
    chk("req_err", req_err, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask

  task automatic req(input bit dir);
    step(1, dir, 1, 0);
    idle(L);
    chk("phase_idle", phase, m_phase);
  endtask

  initial begin
    rst_n = 0; psen = 0; psincdec = 0; ready = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_psdone", psdone, 0);
    chk("rst_busy", busy, 0);
    chk("rst_phase", phase, 0);
    chk("rst_at_limit", at_limit, 0);
    chk("rst_req_err", req_err, 0);
    rst_n = 1; ready = 1;
    mon_en = 1;
    idle(2);

    req(1);
    repeat (3) req(0);

    while (m_phase < PMAX - 1) req(1);
    req(1); req(1); req(0);

    // Overlapping request three cycles in, then clear; then error-and-clear together.
    step(1, 1, 1, 0); idle(2); step(1, 0, 1, 0); idle(L);
    chk("phase_single", phase, m_phase);
    step(0, 0, 1, 1);
    step(1, 0, 1, 0); step(1, 1, 1, 1); idle(L); step(0, 0, 1, 1);

    step(1, 1, 0, 0); idle(L);
    step(1, 0, 1, 0);
    for (int i = 0; i < L; i++) step(0, 0, 0, 0);
    idle(2); step(0, 0, 1, 1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    idle(L + 2);

    while (m_phase > PMIN) req(0);
    req(0); req(1);

    // Asynchronous reset mid-cycle on the fifth SHIFT cycle.
    step(1, 1, 1, 0); idle(4);
    #2 rst_n = 0;
    #1;
    chk("arst_psdone", psdone, 0);
    chk("arst_busy", busy, 0);
    chk("arst_phase", phase, 0);
    chk("arst_at_limit", at_limit, 0);
    chk("arst_req_err", req_err, 0);
    sb.delete(); m_phase = 0; m_err = 0; acc_valid = 0; next_ok = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    idle(L + 5);
    req(0);

    idle(L + 3);
    chk("queue_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps_responder.md
Name: ps_responder

Overview:
- Clock-manager dynamic phase-shift responder: the far end of the psen/psincdec/psdone handshake.
- Accepts one-cycle shift requests, waits a programmable latency, then updates a signed phase offset.
- Returns a one-cycle psdone pulse per accepted request.
- Used as a synthesizable stand-in for the clock manager's phase-shift port, in soft phase-shift paths and in system simulation of phase controllers.

Parameters:
- LATENCY, 12: cycles from accepted psen to psdone assertion; legal range 2..255.
- PS_MAX, 255: upper phase limit (signed steps).
- PS_MIN, -255: lower phase limit (signed steps); PS_MIN < 0 < PS_MAX.
- PW, 10: phase register width (two's complement); must hold PS_MIN..PS_MAX.

Ports:
- clk  in  1  single clock; also serves as the phase-shift clock.
- rst_n  in  1  asynchronous, active-low reset.
- psen  in  1  shift request, one-cycle pulse, sampled on rising clk.
- psincdec  in  1  direction, sampled with psen; 1 = increment, 0 = decrement.
- ready  in  1  responder enabled (lock indication); requests are honoured only when high.
- psdone  out  1  one-cycle completion pulse.
- phase  out  PW  current signed phase offset.
- busy  out  1  high from the cycle after acceptance through the psdone cycle.
- at_limit  out  1  last completed request was clamped at PS_MAX or PS_MIN.
- req_err  out  1  sticky: psen seen while busy or while ready low.
- err_clr  in  1  synchronous clear of req_err.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following immediately:
  - psdone=0, busy=0, at_limit=0, req_err=0, phase=0.
  - state=IDLE, latency counter=0, latched direction=0.
- Any request in flight is discarded; no psdone follows reset release.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - If psen & ready at edge N: latch psincdec, load counter with LATENCY-2, go to SHIFT.
  - If psen & ~ready: ignore the request, set req_err, stay in IDLE.
- SHIFT:
  - Decrement counter each cycle.
  - When counter = 0, go to DONE.
  - psen in SHIFT is ignored (not queued) and sets req_err.
- DONE:
  - psdone=1 for exactly this cycle.
  - Return to IDLE on the next edge.
  - psen in DONE is ignored and sets req_err.
- Latency: psen high at edge N means psdone is high between edges N+LATENCY-1 and N+LATENCY, i.e. it is sampled high at edge N+LATENCY.
- Phase update happens on the edge entering DONE, so phase reflects the new value in the same cycle psdone is high.
  - Increment: if phase < PS_MAX then phase+1 and at_limit=0; else phase unchanged and at_limit=1.
  - Decrement: if phase > PS_MIN then phase-1 and at_limit=0; else phase unchanged and at_limit=1.
- Phase arithmetic is signed, PW bits, with no wrap-around. A clamped request still produces psdone.
- busy = (state != IDLE), registered-state decode.
- ready falling during SHIFT/DONE does not abort: the request completes normally.
- err_clr and a new error event in the same cycle: the error wins, so req_err stays 1.
- Back-to-back: a new psen is accepted in the first IDLE cycle after DONE. Minimum request spacing is LATENCY+1 cycles.
- psdone, busy and at_limit are registered or decoded from registered state. No combinational path from psen to any output.

Test Plan:
- Reset release, ready=1, single psen with psincdec=1, LATENCY=12 -> psdone sampled high exactly 12 edges later for 1 cycle; phase 0->1; busy high 12 cycles; at_limit=0.
- Three decrement requests spaced 13 cycles apart -> three psdone pulses; phase ends at -3; req_err=0.
- Preload phase=254 via 254 increments, then 2 increments -> phase 255, then stays 255; second psdone still pulses with at_limit=1; then one decrement -> phase 254, at_limit=0.
- psen again 3 cycles after an accepted request -> ignored; only one psdone; phase changes by 1; req_err=1; err_clr pulse -> req_err=0.
- ready=0 with psen -> no psdone, phase unchanged, req_err=1. ready dropped mid-SHIFT -> request completes, psdone pulses.
- rst_n asserted low at cycle 5 of SHIFT (asynchronously, mid-cycle) -> outputs clear immediately, phase=0, no psdone after rst_n returns high.
